// File: rtl/hack_rom_loader.sv
// Instruction-store writer for the HACK CPU. A framed program image arrives
// over an 8-bit stream: SYNC, LEN_HI, LEN_LO, 2N data bytes (high byte first),
// and a checksum that is the XOR of the data bytes. Each pair of data bytes is
// written as one 16-bit word. The CPU is held in reset until a frame's
// checksum verifies.
//
// Stream handshake: a byte transfers on a rising clk edge where
// rx_valid && rx_ready. The sender may hold rx_valid for any length of time
// and the loader waits indefinitely. rx_ready is low during reset and during
// the single WRITE cycle that follows every low data byte.
module hack_rom_loader #(
  parameter int         ADDR_W    = 15,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [14:0] pc,
  output logic [15:0] inst,
  output logic        cpu_reset,
  output logic        load_done,
  output logic        err,
  output logic [3:0]  dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [3:0] {
    S_HUNT,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CKSUM,
    S_RUN,
    S_ERROR
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [15:0]     len;
  logic [ADDR_W:0] addr;
  logic [7:0]      csum;
  logic [7:0]      hi;
  logic [7:0]      lo;
  logic [15:0]     mem [DEPTH];

  logic            accept;
  logic            len_bad;
  logic            last_word;
  logic            pc_hi_nz;

  // The loader refuses bytes while reset is asserted and during WRITE.
  assign rx_ready  = reset && (state != S_WRITE);
  assign accept    = rx_valid && rx_ready;
  assign dbg_state = state;

  // Length check uses the byte arriving now as the low half of N.
  assign len_bad   = ({len[15:8], rx_data} == 16'd0) ||
                     (32'({len[15:8], rx_data}) > 32'(DEPTH));

  // addr is one bit wider than the store so a full-depth image ends cleanly.
  assign last_word = (32'(addr) + 32'd1) == 32'(len);

  // Addresses beyond the store read as zero when the store is narrower than pc.
  assign pc_hi_nz  = (32'(pc) >> ADDR_W) != 32'd0;
  assign inst      = pc_hi_nz ? 16'h0000 : mem[pc[ADDR_W-1:0]];

  // State register plus registered CPU control flags decoded from next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_HUNT;
      cpu_reset <= 1'b1;
      load_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nx;
      cpu_reset <= (state_nx != S_RUN);
      load_done <= (state_nx == S_RUN);
      err       <= (state_nx == S_ERROR);
    end
  end

  // Next-state decode of the frame parser.
  always_comb begin
    state_nx = state;
    case (state)
      S_HUNT, S_RUN, S_ERROR: begin
        if (accept && rx_data == SYNC_BYTE) state_nx = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) state_nx = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) state_nx = len_bad ? S_ERROR : S_DATA_HI;
      end
      S_DATA_HI: begin
        if (accept) state_nx = S_DATA_LO;
      end
      S_DATA_LO: begin
        if (accept) state_nx = S_WRITE;
      end
      S_WRITE: begin
        state_nx = last_word ? S_CKSUM : S_DATA_HI;
      end
      S_CKSUM: begin
        if (accept) state_nx = (rx_data == csum) ? S_RUN : S_ERROR;
      end
      default: state_nx = S_HUNT;
    endcase
  end

  // Frame datapath: length, word address, running XOR and the byte pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len  <= 16'd0;
      addr <= '0;
      csum <= 8'd0;
      hi   <= 8'd0;
      lo   <= 8'd0;
    end else begin
      case (state)
        S_LEN_HI: begin
          if (accept) len[15:8] <= rx_data;
        end
        S_LEN_LO: begin
          if (accept) begin
            len[7:0] <= rx_data;
            addr     <= '0;
            csum     <= 8'd0;
          end
        end
        S_DATA_HI: begin
          if (accept) begin
            hi   <= rx_data;
            csum <= csum ^ rx_data;
          end
        end
        S_DATA_LO: begin
          if (accept) begin
            lo   <= rx_data;
            csum <= csum ^ rx_data;
          end
        end
        S_WRITE: begin
          addr <= addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Instruction store write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (state == S_WRITE) mem[addr[ADDR_W-1:0]] <= {hi, lo};
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Bench for hack_rom_loader: directed frames plus randomized frames, with a
// reference model holding the expected instruction store and frame outcome.
module tb_hack_rom_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [14:0] pc;
  logic [15:0] inst;
  logic        cpu_reset;
  logic        load_done;
  logic        err;
  logic [3:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  logic [15:0] ref_mem [int];
  logic [15:0] fw [$];
  logic [15:0] exp_q [$];

  hack_rom_loader #(.ADDR_W(15), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .pc        (pc),
    .inst      (inst),
    .cpu_reset (cpu_reset),
    .load_done (load_done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int max_idle, output int waits);
    int idle;
    idle = (max_idle > 0) ? int'($urandom_range(max_idle, 0)) : 0;
    rx_valid = 1'b0;
    repeat (idle) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data  = b;
    waits    = 0;
    while (!rx_ready && waits < 50) begin @(posedge clk); #1; waits++; end
    if (!rx_ready) check_eq("ready_timeout", 32'(waits), 32'd0);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_raw(input logic [7:0] b);
    int w;
    send_byte(b, 0, w);
  endtask

  task automatic check_outcome(input string tag, input bit ok);
    check_eq({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!ok));
    check_eq({tag, "_load_done"}, 32'(load_done), 32'(ok));
    check_eq({tag, "_err"},       32'(err),       32'(!ok));
  endtask

  // Sends the frame held in fw and updates the reference store.
  task automatic send_frame(input int max_idle, input bit bad_ck, input bit gap_chk);
    logic [7:0] ck;
    logic [7:0] b;
    int n;
    int w;
    bit prev_lo;
    n  = fw.size();
    ck = 8'd0;
    @(posedge clk); #1;
    send_byte(8'hA5, max_idle, w);
    check_eq("sync_err_clr", 32'(err), 32'd0);
    check_eq("sync_cpu_rst", 32'(cpu_reset), 32'd1);
    send_byte(8'(n >> 8), max_idle, w);
    send_byte(8'(n), max_idle, w);
    prev_lo = 1'b0;
    for (int i = 0; i < n; i++) begin
      b = fw[i][15:8];
      send_byte(b, max_idle, w);
      if (gap_chk) check_eq("gap_hi", 32'(w), prev_lo ? 32'd1 : 32'd0);
      ck = ck ^ b;
      b = fw[i][7:0];
      send_byte(b, max_idle, w);
      if (gap_chk) check_eq("gap_lo", 32'(w), 32'd0);
      ck = ck ^ b;
      prev_lo = 1'b1;
      ref_mem[i] = fw[i];
    end
    check_eq("held_in_reset", 32'(cpu_reset), 32'd1);
    send_byte(bad_ck ? (ck ^ 8'h01) : ck, max_idle, w);
    if (gap_chk) check_eq("gap_ck", 32'(w), 32'd1);
    check_outcome("frame", !bad_ck);
  endtask

  task automatic verify_mem(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[i]);
    for (int i = 0; i < n; i++) begin
      pc = 15'(i);
      #1;
      check_eq("inst", 32'(inst), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic random_words(input int n);
    fw.delete();
    for (int i = 0; i < n; i++) fw.push_back(16'($urandom));
  endtask

  initial begin
    logic [7:0] g;
    int n;
    bit bad;
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    pc       = 15'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rx_ready",  32'(rx_ready),  32'd0);
    check_eq("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check_eq("rst_load_done", 32'(load_done), 32'd0);
    check_eq("rst_err",       32'(err),       32'd0);
    reset = 1'b1;
    #1;
    check_eq("rel_rx_ready", 32'(rx_ready), 32'd1);

    // Two-word image with WRITE bubble checks
    fw = '{16'h1234, 16'hABCD};
    send_frame(0, 1'b0, 1'b1);
    verify_mem(2);

    // Bad checksum, then a good one-word frame out of ERROR
    send_frame(0, 1'b1, 1'b0);
    fw = '{16'h0007};
    send_frame(0, 1'b0, 1'b0);
    verify_mem(2);

    // Garbage ahead of SYNC is dropped
    @(posedge clk); #1;
    send_raw(8'h00); send_raw(8'hFF); send_raw(8'h5A);
    check_outcome("garbage_run", 1'b1);
    random_words(2);
    send_frame(0, 1'b0, 1'b0);
    verify_mem(2);

    // Zero length and oversize length
    send_raw(8'hA5); send_raw(8'h00); send_raw(8'h00);
    check_outcome("len_zero", 1'b0);
    send_raw(8'hA5); send_raw(8'h80); send_raw(8'h01);
    check_outcome("len_big", 1'b0);

    // Reload from RUN
    fw = '{16'h1357, 16'hABCD};
    send_frame(0, 1'b0, 1'b0);
    send_raw(8'hA5);
    check_eq("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    check_eq("reload_load_done", 32'(load_done), 32'd0);
    send_raw(8'h00); send_raw(8'h01); send_raw(8'hBE); send_raw(8'hEF); send_raw(8'h51);
    ref_mem[0] = 16'hBEEF;
    check_outcome("reload", 1'b1);
    verify_mem(2);

    // Reset in the WRITE cycle of word 0 of a 3-word frame
    send_raw(8'hA5); send_raw(8'h00); send_raw(8'h03); send_raw(8'h11); send_raw(8'h11);
    reset = 1'b0;
    #1;
    check_eq("mid_rx_ready",  32'(rx_ready),  32'd0);
    check_eq("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    check_eq("mid_load_done", 32'(load_done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_eq("mid_hold_ready", 32'(rx_ready), 32'd0);
    reset = 1'b1;
    random_words(3);
    send_frame(0, 1'b0, 1'b0);
    verify_mem(3);

    // 64 words unthrottled, complement image, then the same 64 throttled
    random_words(64);
    send_frame(0, 1'b0, 1'b0);
    verify_mem(64);
    for (int i = 0; i < 64; i++) fw[i] = ~fw[i];
    send_frame(0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) fw[i] = ~fw[i];
    send_frame(5, 1'b0, 1'b0);
    verify_mem(64);

    // Randomized frames with optional garbage, throttling and bad checksum
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      repeat ($urandom_range(3, 0)) begin
        do g = 8'($urandom_range(255, 0)); while (g == 8'hA5);
        send_raw(g);
      end
      n   = int'($urandom_range(40, 1));
      bad = ($urandom_range(2, 0) == 0);
      random_words(n);
      send_frame(int'($urandom_range(3, 0)), bad, 1'b0);
      verify_mem(n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
- Writer side of the instruction-fetch interface: owns the instruction store the CPU reads by `pc`, and fills it from a byte stream.
- Accepts a framed program image over an 8-bit valid/ready stream and assembles big-endian 16-bit words.
- Verifies a checksum, then releases the CPU from reset.
- Sits beside the HACK top: drives `inst` and the CPU reset line; takes `pc` from the CPU.

Parameters:
- ADDR_W, 15: word-address width of the instruction store; depth = 2**ADDR_W words.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  incoming stream byte.
- rx_valid  input  1  rx_data valid.
- rx_ready  output  1  block accepts a byte this cycle; a byte transfers when rx_valid && rx_ready at a rising edge.
- pc  input  15  CPU fetch address.
- inst  output  16  instruction word at pc.
- cpu_reset  output  1  active-high reset to the CPU.
- load_done  output  1  high while a verified image is running.
- err  output  1  high after a malformed or failed frame.

Behaviour:
- Reset (reset=0, async): state=HUNT, cpu_reset=1, load_done=0, err=0, rx_ready=0 while asserted. Word counter, address and checksum = 0. Memory contents are not cleared.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO (N words, 16-bit), 2N data bytes (high byte first), CKSUM.
- CKSUM = XOR of all 2N data bytes. Length bytes are excluded.
- States:
  - HUNT: bytes other than SYNC_BYTE are dropped. SYNC_BYTE -> LEN_HI.
  - LEN_HI: store the byte -> LEN_LO.
  - LEN_LO: store the byte. N=0 or N>2**ADDR_W -> ERROR. Otherwise clear addr and checksum -> DATA_HI.
  - DATA_HI: latch the high byte -> DATA_LO.
  - DATA_LO: latch the low byte -> WRITE.
  - WRITE: one cycle with rx_ready=0. Write mem[addr] = {hi,lo} and increment addr. If addr+1==N -> CKSUM, else -> DATA_HI.
  - CKSUM: byte equals the running XOR -> RUN, else -> ERROR.
  - RUN: cpu_reset=0, load_done=1. SYNC_BYTE -> LEN_HI with cpu_reset=1 and load_done=0 from the next cycle (reload). Other bytes are dropped.
  - ERROR: err=1, cpu_reset=1, load_done=0. SYNC_BYTE -> LEN_HI and clears err. Other bytes are dropped.
- rx_ready=1 in every state except WRITE and during reset.
- cpu_reset=1 in every state except RUN. It is registered: it deasserts the cycle after the accepting CKSUM edge.
- load_done is registered with the same timing as cpu_reset.
- Running XOR updates on every accepted data byte.
- inst: combinational read of mem[pc[ADDR_W-1:0]] in all states. When ADDR_W<15 and upper pc bits are nonzero, inst=16'h0000.
  - During a load the CPU is held in reset, so inst is don't-care for verification outside RUN.
- Write/read collision: a WRITE to the address currently on pc returns the new word from the cycle after the edge.
- Counter widths: addr is ADDR_W+1 bits, so N = 2**ADDR_W completes without wrap.
- Reset mid-frame: returns to HUNT. The partially written image stays in memory but load_done=0.
- rx_valid deasserted mid-frame: state holds indefinitely; there is no timeout.

Test Plan:
- Reset release, then stream A5 00 02 12 34 AB CD (12^34^AB^CD=40) 40 -> rx_ready low for exactly one cycle after each low byte. cpu_reset falls the cycle after the 40 is accepted; load_done=1. pc=0 -> inst=16'h1234; pc=1 -> 16'hABCD.
- Same frame with checksum 41 -> err=1, cpu_reset stays 1, load_done=0. Then a valid frame A5 00 01 00 07 00 07 -> err clears at LEN_HI, RUN with inst@0=16'h0007.
- Garbage bytes 00 FF 5A before A5 -> ignored, load succeeds. A5 00 00 -> ERROR immediately after LEN_LO.
- While in RUN, send A5 -> cpu_reset=1 the next cycle. Complete the reload of 1 word 16'hBEEF (cksum 51) -> inst@0=16'hBEEF, previous word 1 unchanged.
- Assert reset after DATA_LO of word 0 in a 3-word frame -> asynchronous return: cpu_reset=1, load_done=0, rx_ready=0 during reset. After release a fresh frame loads correctly.
- Throttle rx_valid randomly, 0-5 idle cycles between bytes, over a 64-word frame -> identical memory contents and checksum result as the unthrottled run.
